// File: rtl/lrf_pkg.sv
// rtl/lrf_pkg.sv - shared sizing helpers and state type for the LSU frame scheduler
package lrf_pkg;

  localparam int PIXELS_PER_BEAT = 16;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int mem_depth(input int image_dim, input int pixels_per_beat);
    return (image_dim * image_dim) / pixels_per_beat;
  endfunction

endpackage

// File: rtl/lsu_out_fifo.sv
// rtl/lsu_out_fifo.sv - 2-entry output buffer; entry 0 is always the head
module lsu_out_fifo #(
  parameter int WIDTH = 129
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] e0;
  logic [WIDTH-1:0] e1;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= din;
          else e1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        // Simultaneous push and pop keeps occupancy; the new entry lands behind any survivor.
        2'b11: begin
          if (occ == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0;

endmodule

// File: rtl/lsu_frame_sched.sv
// rtl/lsu_frame_sched.sv - fills one frame into the buffer RAM, then drains it downstream in order
module lsu_frame_sched
  import lrf_pkg::*;
#(
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 14,
  parameter int PIXELS_PER_BEAT = lrf_pkg::PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int MEM_DEPTH = mem_depth(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam logic [ADDR_WIDTH-1:0] LAST_W = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LAST_R = (ADDR_WIDTH + 1)'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   END_R  = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] wcnt;
  logic [ADDR_WIDTH:0]   rcnt;
  logic                  inflight;
  logic                  inflight_last;
  logic                  frame_done_q;
  logic [DATA_WIDTH:0]   fifo_head;
  logic [1:0]            occ;
  logic [2:0]            level;
  logic                  accept;
  logic                  pop;
  logic                  issue;
  logic                  last_pop;

  assign accept   = (state == FILL) && s_valid;
  assign pop      = (occ != 2'd0) && m_ready;
  assign last_pop = pop && fifo_head[0];
  // Entries held plus the read still in flight, after this cycle's pop, must leave room.
  assign level    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue    = (state == DRAIN) && (rcnt < END_R) && (level < 3'd2);

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (accept && (wcnt == LAST_W)) state_next = DRAIN;
      DRAIN:   if (last_pop) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    s_ready    = (state == FILL);
    busy       = (state == DRAIN);
    mem_we     = accept;
    mem_waddr  = wcnt;
    mem_wdata  = s_data;
    mem_re     = issue;
    mem_raddr  = rcnt[ADDR_WIDTH-1:0];
    m_valid    = (occ != 2'd0);
    m_data     = fifo_head[DATA_WIDTH:1];
    m_last     = fifo_head[0];
    frame_done = frame_done_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt          <= '0;
      rcnt          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q  <= last_pop;
      inflight      <= issue;
      inflight_last <= issue && (rcnt == LAST_R);
      if (accept) wcnt <= (wcnt == LAST_W) ? '0 : wcnt + 1'b1;
      if (last_pop) rcnt <= '0;
      else if (issue) rcnt <= rcnt + 1'b1;
    end
  end

  lsu_out_fifo #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_out_fifo (
    .clk  (clk),
    .reset(reset),
    .push (inflight),
    .pop  (pop),
    .din  ({mem_rdata, inflight_last}),
    .head (fifo_head),
    .occ  (occ)
  );

endmodule

// File: tb/tb_lsu_frame_sched.sv
// tb/tb_lsu_frame_sched.sv - scoreboard bench for lsu_frame_sched with a 1-cycle-read RAM model
module tb_lsu_frame_sched;

  localparam int DW    = 128;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata = '0;
  logic          frame_done;
  logic          busy;
  logic [DW-1:0] ram [DEPTH];

  lsu_frame_sched #(
    .IMAGE_DIM(16),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .PIXELS_PER_BEAT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_raddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [DW:0]   exp_q[$];
  logic [DW:0]   e;
  bit            exp_fill = 1'b1;
  bit            fd_exp = 1'b0;
  bit            seen_valid = 1'b0;
  bit            prev_stall = 1'b0;
  bit            prev_last = 1'b0;
  bit            drain_now;
  bit            drain_done = 1'b0;
  bit            steady = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            wexp = 0;
  int            rexp = 0;
  int            outst = 0;
  int            dcyc = 0;
  int            frame_pops = 0;

  // Monitor: tracks the expected FILL/DRAIN phase and scores every output beat.
  always @(negedge clk) begin
    if (!reset) begin
      drain_now = !exp_fill;
      check("s_ready", s_ready, exp_fill);
      check("busy", busy, drain_now);
      check("mem_we", mem_we, s_valid && exp_fill);
      check("frame_done", frame_done, fd_exp);
      if (frame_done && fd_exp) drain_done = 1'b1;
      fd_exp = 1'b0;
      if (s_valid && exp_fill) begin
        check("mem_waddr", mem_waddr, wexp);
        check("mem_wdata", mem_wdata, s_data);
        wexp++;
        if (wexp == DEPTH) begin
          wexp = 0; exp_fill = 1'b0; dcyc = -1;
          seen_valid = 1'b0; rexp = 0; outst = 0;
        end
      end
      check("mem_re_gate", mem_re && !drain_now, 1'b0);
      if (mem_re) begin
        check("mem_raddr", mem_raddr, rexp);
        if (rexp == 0) check("first_read_cycle", dcyc, 0);
        rexp++;
        outst++;
      end
      if (m_valid && !seen_valid && drain_now) begin
        seen_valid = 1'b1;
        check("first_valid_lat", dcyc, 2);
      end
      if (prev_stall) begin
        check("stall_valid", m_valid, 1'b1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got %0h with empty scoreboard", m_data);
        end else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e[DW:1]);
          check("m_last", m_last, e[0]);
          if (steady) check("beat_cycle", dcyc, 2 + frame_pops);
          if (e[0]) begin fd_exp = 1'b1; exp_fill = 1'b1; end
        end
        frame_pops++;
        outst--;
      end
      check("outstanding_le2", outst <= 2, 1'b1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      dcyc++;
    end
  end

  task automatic fill(input logic [DW-1:0] base, input bit rnd);
    int n = 0;
    int guard = 0;
    frame_pops = 0;
    while (n < DEPTH && guard < 200) begin
      @(posedge clk); #1;
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = base + DW'(n);
      @(negedge clk);
      if (s_valid && s_ready) begin
        exp_q.push_back({s_data, n == DEPTH - 1});
        n++;
      end
      guard++;
    end
    if (n < DEPTH) begin
      checks++; errors++;
      $display("FAIL fill_timeout: got %0d beats expected %0d", n, DEPTH);
    end
  endtask

  // mode 0: ready held, 1: ready toggling, 2: 20-cycle stall, 3: reset after 7 beats
  task automatic drain(input int mode, input logic [DW-1:0] base, input bit hold);
    int cyc = 0;
    int nre = 0;
    bit aborted = 1'b0;
    drain_done = 1'b0;
    steady = (mode == 0);
    while (!drain_done && cyc < 300) begin
      @(posedge clk); #1;
      if (!hold || frame_pops >= DEPTH) s_valid = 1'b0;
      if (mode == 3 && frame_pops >= 7) begin
        reset = 1'b1;
        aborted = 1'b1;
        break;
      end
      case (mode)
        1:       m_ready = (cyc % 2 == 0);
        2:       m_ready = (cyc >= 20);
        default: m_ready = 1'b1;
      endcase
      @(negedge clk);
      if (mode == 2 && cyc < 20 && mem_re) nre++;
      if (mode == 2 && cyc == 19) begin
        check("stall_reads", nre, 2);
        check("stall_valid_hold", m_valid, 1'b1);
        check("stall_head", m_data, base);
      end
      cyc++;
    end
    steady = 1'b0;
    m_ready = 1'b0;
    if (aborted) begin
      @(negedge clk);
      @(negedge clk);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_s_ready", s_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      exp_q.delete();
      exp_fill = 1'b1; wexp = 0; fd_exp = 1'b0; prev_stall = 1'b0;
      frame_pops = 0; outst = 0; rexp = 0;
      @(posedge clk); #1;
      reset = 1'b0;
    end else if (!drain_done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d beats expected %0d", frame_pops, DEPTH);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_s_ready", s_ready, 1'b1);
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_m_last", m_last, 1'b0);
    check("reset_mem_we", mem_we, 1'b0);
    check("reset_mem_re", mem_re, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_waddr", mem_waddr, 0);
    check("reset_raddr", mem_raddr, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    fill(0, 1'b0);   drain(0, 0, 1'b1);
    fill(32, 1'b0);  drain(1, 32, 1'b0);
    fill(64, 1'b0);  drain(2, 64, 1'b0);
    fill(96, 1'b1);  drain(0, 96, 1'b0);
    fill(128, 1'b0); drain(3, 128, 1'b0);
    fill(160, 1'b0); drain(0, 160, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_frame_sched.md
# lsu_frame_sched

Frame-level scheduler for the LSU frame buffer: accepts one full frame of beats from the upstream pixel stream, writes it into the buffer RAM, then drains it in order to the downstream stage under valid/ready backpressure. It owns buffer addressing and read/write enables, so the RAM never sees an unpaced access. It sits between the fusion-stage output stream and the next pipeline stage, wrapping a single addressed frame-buffer RAM.

## Interface
- IMAGE_DIM, 512, image side in pixels (square frame)
- DATA_WIDTH, 128, beat width (16 pixels x 8 bit)
- ADDR_WIDTH, 14, buffer address width; must satisfy 2^ADDR_WIDTH >= MEM_DEPTH
- PIXELS_PER_BEAT, 16, pixels per beat; MEM_DEPTH = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT (16384 at defaults)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- s_valid  in  1  upstream beat valid
- s_ready  out  1  upstream ready; high only in FILL
- s_data  in  DATA_WIDTH  upstream beat
- m_valid  out  1  downstream beat valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_WIDTH  downstream beat
- m_last  out  1  qualifies final beat of frame (with m_valid)
- mem_we  out  1  RAM write enable
- mem_waddr  out  ADDR_WIDTH  RAM write address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_re  out  1  RAM read enable
- mem_raddr  out  ADDR_WIDTH  RAM read address
- mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after mem_re
- frame_done  out  1  one-cycle pulse after the last output beat handshakes
- busy  out  1  high in DRAIN

## Operation
- States: FILL, DRAIN. Reset state FILL.
- FILL: s_ready=1. Accept = s_valid & s_ready. On accept: mem_we=1, mem_waddr=wcnt, mem_wdata=s_data (combinational pass-through), wcnt++. Accept with wcnt==MEM_DEPTH-1 -> DRAIN, wcnt<=0.
- DRAIN: s_ready=0, no writes. Read counter rcnt issues reads 0..MEM_DEPTH-1 in order. Output buffer: 2-entry FIFO of {data,last}. inflight = mem_re of previous cycle. Issue mem_re when rcnt < MEM_DEPTH and (occ + inflight - pop) < 2, pop = m_valid & m_ready. Captured entry's last = (captured address == MEM_DEPTH-1).
- m_valid = FIFO non-empty; m_data/m_last = FIFO head.
- Pop of entry with last=1 -> frame_done=1 next cycle, state FILL, rcnt<=0. FIFO is empty at that point by construction.
- Counters ADDR_WIDTH+1 bits for rcnt (end detection), ADDR_WIDTH for wcnt; no wrap beyond MEM_DEPTH.
- Simultaneous capture and pop on same cycle: both occur, occupancy unchanged.
- Reset mid-frame (either state): state FILL, wcnt=rcnt=0, FIFO flushed, inflight read discarded; partial frame lost.

## Timing
- Reset values: s_ready=1 (state FILL), m_valid=0, m_last=0, mem_we=0 (s_valid-gated), mem_re=0, frame_done=0, busy=0, addresses 0.
- Write path: zero latency; beat accepted in cycle t is written at edge ending t.
- First DRAIN cycle D (cycle after final accept): mem_re=1, raddr=0. Data captured at end of D+1; m_valid=1 first in D+2.
- With m_ready held high: one output beat per cycle, last beat in D+MEM_DEPTH+1, frame_done in D+MEM_DEPTH+2, s_ready=1 in same cycle as frame_done.
- m_valid/m_data/m_last stable while m_valid & ~m_ready (AXI-stream rule).
- m_ready low: at most 2 reads outstanding+buffered; reads resume the cycle a pop is seen.

## Structure
- Shared package lrf_pkg: PIXELS_PER_BEAT, MEM_DEPTH derivation function, state enum {FILL, DRAIN}.
- One sub-module: lsu_out_fifo (2-entry, DATA_WIDTH+1 wide, push/pop/occ). RAM itself is external.

## Test plan
Bench uses IMAGE_DIM=16 (MEM_DEPTH=16), ADDR_WIDTH=4, RAM model with 1-cycle read.
- Reset then s_valid=1 continuous, s_data=beat index -> mem_waddr 0..15, busy rises after beat 15, s_ready=0 during DRAIN.
- Full frame, m_ready=1 -> m_data 0..15 consecutive cycles, first m_valid 2 cycles after DRAIN entry, m_last only on 15, frame_done 1 cycle later.
- Drain with m_ready toggling 1010... -> all 16 beats in order, no duplicates/drops, m_data stable while stalled, never >2 reads outstanding+buffered.
- m_ready=0 for 20 cycles in DRAIN -> exactly 2 mem_re issued, m_valid held with m_data=0.
- Upstream s_valid random 50% in FILL -> writes only on accept, wcnt dense 0..15.
- reset asserted at beat 7 of DRAIN -> next cycle m_valid=0, s_ready=1, busy=0; following frame drains cleanly from beat 0.
